// File: rtl/muldiv_seq.sv
// RV32M multiply/divide responder: shift-add multiply, restoring divide, one shared datapath.
// Latency: request cycle + 32/ITER_BITS CALC cycles busy, result in the DONE cycle; divide specials finish in 1 busy cycle.
// Backpressure: o_busy stalls the requester while i_md_en is high; dropping i_md_en mid-CALC aborts the operation.
module muldiv_seq #(
  parameter int ITER_BITS = 1
) (
  input  logic        i_clk_n,
  input  logic        i_rst,
  input  logic [31:0] i_in_a,
  input  logic [31:0] i_in_b,
  input  logic [2:0]  i_funct3,
  input  logic        i_md_en,
  output logic [31:0] o_result,
  output logic        o_busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [4:0] CNT_STEP = 5'(ITER_BITS);
  localparam logic [4:0] CNT_LAST = 5'(32 - ITER_BITS);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;     // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
  logic [31:0] opb_q, opb_d;     // multiplicand or divisor magnitude
  logic [2:0]  f3_q, f3_d;
  logic        neg_q, neg_d;     // final result must be negated
  logic [31:0] result_q, result_d;

  logic        a_sgn, b_sgn, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic        is_div, div_zero, div_ovf, res_neg;
  logic [63:0] acc_nxt;
  logic [32:0] sum, rem;
  logic [31:0] quo;
  logic [63:0] prod_f;
  logic [31:0] quo_f, rem_f, final_res;

  // Operand conditioning on the incoming request: magnitudes, signs, special cases
  always_comb begin
    a_sgn    = (i_funct3 == 3'b001) || (i_funct3 == 3'b010) ||
               (i_funct3 == 3'b100) || (i_funct3 == 3'b110);
    b_sgn    = (i_funct3 == 3'b001) || (i_funct3 == 3'b100) || (i_funct3 == 3'b110);
    a_neg    = a_sgn && i_in_a[31];
    b_neg    = b_sgn && i_in_b[31];
    a_mag    = a_neg ? (~i_in_a + 32'd1) : i_in_a;
    b_mag    = b_neg ? (~i_in_b + 32'd1) : i_in_b;
    is_div   = i_funct3[2];
    div_zero = is_div && (i_in_b == 32'd0);
    div_ovf  = is_div && !i_funct3[0] &&
               (i_in_a == 32'h8000_0000) && (i_in_b == 32'hFFFF_FFFF);
    case (i_funct3)
      3'b001, 3'b010, 3'b100: res_neg = a_neg ^ b_neg;
      3'b110:                 res_neg = a_neg;  // remainder follows the dividend
      default:                res_neg = 1'b0;
    endcase
  end

  // Shared iteration datapath: ITER_BITS multiply or divide steps per cycle
  always_comb begin
    acc_nxt = acc_q;
    sum     = '0;
    rem     = '0;
    quo     = '0;
    for (int i = 0; i < ITER_BITS; i++) begin
      if (!f3_q[2]) begin
        // add multiplicand when the multiplier LSB is set, then shift right with carry
        sum     = {1'b0, acc_nxt[63:32]} + (acc_nxt[0] ? {1'b0, opb_q} : 33'd0);
        acc_nxt = {sum, acc_nxt[31:1]};
      end else begin
        // shift next dividend bit into the remainder; subtract divisor if it fits
        rem = {acc_nxt[63:32], acc_nxt[31]};
        quo = {acc_nxt[30:0], 1'b0};
        if (rem >= {1'b0, opb_q}) begin
          rem    = rem - {1'b0, opb_q};
          quo[0] = 1'b1;
        end
        acc_nxt = {rem[31:0], quo};
      end
    end
  end

  // Sign correction and word select for the result registered on entry to DONE
  always_comb begin
    prod_f    = neg_q ? (~acc_nxt + 64'd1) : acc_nxt;
    quo_f     = neg_q ? (~acc_nxt[31:0] + 32'd1) : acc_nxt[31:0];
    rem_f     = neg_q ? (~acc_nxt[63:32] + 32'd1) : acc_nxt[63:32];
    final_res = '0;
    case (f3_q)
      3'b000:                 final_res = prod_f[31:0];
      3'b001, 3'b010, 3'b011: final_res = prod_f[63:32];
      3'b100, 3'b101:         final_res = quo_f;
      default:                final_res = rem_f;
    endcase
  end

  // Next-state and datapath load control for the IDLE/CALC/DONE sequencer
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (i_md_en) begin
          f3_d  = i_funct3;
          cnt_d = '0;
          if (div_zero) begin
            result_d = i_funct3[1] ? i_in_a : 32'hFFFF_FFFF;
            state_d  = DONE;
          end else if (div_ovf) begin
            result_d = i_funct3[1] ? 32'd0 : 32'h8000_0000;
            state_d  = DONE;
          end else begin
            // both ops start with A in the low word: multiplier or dividend
            acc_d   = {32'd0, a_mag};
            opb_d   = b_mag;
            neg_d   = res_neg;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (!i_md_en) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_nxt;
          cnt_d = cnt_q + CNT_STEP;
          if (cnt_q == CNT_LAST) begin
            result_d = final_res;
            state_d  = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything including the result
  always_ff @(posedge i_clk_n or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign o_busy   = i_md_en && (state_q != DONE);
  assign o_result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: scoreboard of expected results and busy lengths, monitored on the falling edge.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic [2:0]  f3;
  logic        md_en;
  logic [31:0] res;
  logic        busy;

  always #5 clk = ~clk;

  muldiv_seq #(.ITER_BITS(1)) dut (
    .i_clk_n  (clk),
    .i_rst    (rst),
    .i_in_a   (a),
    .i_in_b   (b),
    .i_funct3 (f3),
    .i_md_en  (md_en),
    .o_result (res),
    .o_busy   (busy)
  );

  typedef struct {
    logic [31:0] res;
    int          lat;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          busy_cnt = 0;
  logic [31:0] last_res = 32'd0;

  // Reference: RV32M semantics in plain 64-bit / integer arithmetic
  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    int          sx, sy, q;
    logic        ovf;
    sx  = x;
    sy  = y;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    p   = '0;
    q   = 0;
    case (f)
      3'd0: begin p = {32'd0, x} * {32'd0, y}; return p[31:0]; end
      3'd1: begin p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y}); return p[63:32]; end
      3'd2: begin p = $signed({{32{x[31]}}, x}) * $signed({32'd0, y}); return p[63:32]; end
      3'd3: begin p = {32'd0, x} * {32'd0, y}; return p[63:32]; end
      3'd4: begin
        if (y == 32'd0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        q = sx / sy;
        return q;
      end
      3'd5: return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 32'd0) return x;
        if (ovf) return 32'd0;
        q = sx % sy;
        return q;
      end
      default: return (y == 32'd0) ? x : x % y;
    endcase
  endfunction

  // Busy cycles seen by the requester: 1 for divide specials, else request + 32 iterations
  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    if (f[2] && ((y == 32'd0) || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)))
      return 1;
    return 33;
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'd1;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: counts busy cycles and pops the scoreboard whenever a result is presented
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst === 1'b1 || md_en !== 1'b1) begin
      busy_cnt = 0;
    end else if (busy === 1'b1) begin
      busy_cnt++;
    end else begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_result: got %h with no request outstanding", res);
      end else begin
        e = sb_q.pop_front();
        if (res !== e.res) begin
          n_errors++;
          $display("FAIL result f3=%0d a=%h b=%h: got %h expected %h", e.f3, e.a, e.b, res, e.res);
        end
        n_checks++;
        if (busy_cnt != e.lat) begin
          n_errors++;
          $display("FAIL latency f3=%0d a=%h b=%h: got %0d busy cycles expected %0d",
                   e.f3, e.a, e.b, busy_cnt, e.lat);
        end
      end
      busy_cnt = 0;
    end
  end

  // Issue one request (called just after a rising edge), wait for its result, optionally keep md_en high
  task automatic do_req(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y, input bit keep);
    exp_t e;
    bit   done;
    f3    = f;
    a     = x;
    b     = y;
    md_en = 1'b1;
    e.res = ref_res(f, x, y);
    e.lat = ref_lat(f, x, y);
    e.f3  = f;
    e.a   = x;
    e.b   = y;
    sb_q.push_back(e);
    last_res = e.res;
    done = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL timeout f3=%0d a=%h b=%h: busy still %b after 100 cycles, expected 0", f, x, y, busy);
    end
    @(posedge clk);
    #1;
    if (!keep) begin
      md_en = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst   = 1'b1;
    md_en = 1'b0;
    a     = '0;
    b     = '0;
    f3    = '0;
    repeat (2) @(posedge clk);
    #1;
    check32("reset_result", res, 32'd0);
    check32("reset_busy_idle", {31'd0, busy}, 32'd0);
    md_en = 1'b1;
    #1;
    check32("reset_busy_follows_en", {31'd0, busy}, 32'd1);
    md_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // directed cases
    do_req(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);
    do_req(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    do_req(3'd3, 32'h8000_0000, 32'h8000_0000, 1'b0);
    do_req(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    do_req(3'd5, 32'd100, 32'd7, 1'b0);
    do_req(3'd7, 32'd100, 32'd7, 1'b0);
    do_req(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_req(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_req(3'd4, 32'd5, 32'd0, 1'b0);
    do_req(3'd6, 32'd5, 32'd0, 1'b0);
    do_req(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_req(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    // back-to-back with md_en held across the DONE cycle
    do_req(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    do_req(3'd5, 32'hDEAD_BEEF, 32'd13, 1'b0);

    // abort at CALC cycle 10: result must not change afterwards
    f3    = 3'd1;
    a     = 32'hCAFE_F00D;
    b     = 32'h0BAD_F00D;
    md_en = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    md_en = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check32("abort_result_held", res, last_res);
    do_req(3'd1, 32'hCAFE_F00D, 32'h0BAD_F00D, 1'b0);

    // reset at CALC cycle 20: result cleared immediately
    f3    = 3'd3;
    a     = 32'hFFFF_0001;
    b     = 32'h7777_7777;
    md_en = 1'b1;
    repeat (21) @(posedge clk);
    #1;
    rst   = 1'b1;
    md_en = 1'b0;
    #1;
    check32("midcalc_reset_result", res, 32'd0);
    check32("midcalc_reset_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_res = 32'd0;
    repeat (40) @(posedge clk);
    #1;
    check32("post_reset_result", res, last_res);
    do_req(3'd3, 32'hFFFF_0001, 32'h7777_7777, 1'b0);

    // randomized traffic, mixed gaps and back-to-back
    for (int n = 0; n < 150; n++) begin
      do_req(3'($urandom_range(0, 7)), rnd_op(), rnd_op(), bit'($urandom_range(0, 1)));
    end
    md_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check32("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
